// File: rtl/sram_bank_arbiter.sv
// Two-port round-robin arbiter in front of a shared SRAM bank.
// Range-checks word addresses and returns rdata/err to the owner one cycle after grant.
module sram_bank_arbiter #(
    parameter int unsigned NUM_SRAM = 7,
    parameter int unsigned ADDR_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [3:0]        p0_be,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [3:0]        p1_be,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // One spare bit so that NUM_SRAM*1024 itself is always representable.
    localparam logic [ADDR_W-2:0] WORD_LIMIT = (ADDR_W-1)'(NUM_SRAM * 1024);

    logic              r_prio;
    logic              r_rv_valid;
    logic              r_rv_owner;
    logic              r_rv_read;
    logic              r_rv_err;

    logic              w_win_valid;
    logic              w_win;
    logic              w_sel_we;
    logic [3:0]        w_sel_be;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_in_range;
    logic              w_rd_ok;

    always_comb begin
        w_win_valid = (p0_req | p1_req) & ~rst;
        w_win       = (p0_req & p1_req) ? r_prio : p1_req;
        w_sel_we    = 1'b0;
        w_sel_be    = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        if (w_win_valid) begin
            if (w_win) begin
                w_sel_we    = p1_we;
                w_sel_be    = p1_be;
                w_sel_addr  = p1_addr;
                w_sel_wdata = p1_wdata;
            end else begin
                w_sel_we    = p0_we;
                w_sel_be    = p0_be;
                w_sel_addr  = p0_addr;
                w_sel_wdata = p0_wdata;
            end
        end
        w_in_range = {1'b0, w_sel_addr[ADDR_W-1:2]} < WORD_LIMIT;
    end

    assign p0_gnt    = w_win_valid & ~w_win;
    assign p1_gnt    = w_win_valid & w_win;
    assign mem_req   = w_win_valid & w_in_range;
    assign mem_we    = w_sel_we;
    assign mem_be    = w_sel_be;
    assign mem_addr  = w_sel_addr;
    assign mem_wdata = w_sel_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio     <= 1'b0;
            r_rv_valid <= 1'b0;
            r_rv_owner <= 1'b0;
            r_rv_read  <= 1'b0;
            r_rv_err   <= 1'b0;
        end else begin
            r_rv_valid <= w_win_valid;
            r_rv_owner <= w_win;
            r_rv_read  <= ~w_sel_we;
            r_rv_err   <= ~w_in_range;
            if (w_win_valid) begin
                r_prio <= ~w_win;
            end
        end
    end

    // Writes and out-of-range accesses return zero data.
    assign w_rd_ok   = r_rv_read & ~r_rv_err;
    assign p0_rvalid = r_rv_valid & ~r_rv_owner;
    assign p1_rvalid = r_rv_valid & r_rv_owner;
    assign p0_rdata  = (p0_rvalid & w_rd_ok) ? mem_rdata : '0;
    assign p1_rdata  = (p1_rvalid & w_rd_ok) ? mem_rdata : '0;
    assign p0_err    = p0_rvalid & r_rv_err;
    assign p1_err    = p1_rvalid & r_rv_err;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_sram_bank_arbiter;

    localparam int unsigned NUM_SRAM = 7;
    localparam int unsigned ADDR_W   = 24;
    localparam int          NWORDS   = NUM_SRAM * 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [3:0]        p0_be, p1_be;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [31:0]       p0_wdata, p1_wdata;
    logic              p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_req, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: favoured port and the one response in flight.
    int m_prio = 0;
    bit m_pv   = 0;
    int m_po   = 0;
    bit m_pr   = 0;
    bit m_pe   = 0;

    sram_bank_arbiter #(.NUM_SRAM(NUM_SRAM), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic bit in_rng(input logic [ADDR_W-1:0] a);
        return int'(a >> 2) < NWORDS;
    endfunction

    function automatic int model_winner();
        if (rst) return -1;
        if (p0_req && p1_req) return m_prio;
        if (p0_req) return 0;
        if (p1_req) return 1;
        return -1;
    endfunction

    function automatic bit exp_rvalid(input int n);
        return m_pv && (m_po == n);
    endfunction

    function automatic logic [31:0] exp_rdata(input int n);
        return (exp_rvalid(n) && m_pr && !m_pe) ? mem_rdata : 32'h0;
    endfunction

    // Advance the model by one clock from the inputs of the current cycle.
    task automatic next_cycle();
        int w;
        w = model_winner();
        if (rst) begin
            m_prio = 0;
            m_pv   = 0;
        end else begin
            m_pv = (w >= 0);
            if (w >= 0) begin
                m_po   = w;
                m_pr   = (w == 1) ? !p1_we : !p0_we;
                m_pe   = !in_rng((w == 1) ? p1_addr : p0_addr);
                m_prio = 1 - w;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_be = '0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_be = '0; p1_addr = '0; p1_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        p0_req = 1; p1_req = 1; p0_addr = 24'h000100; p1_addr = 24'h000200;
        mem_rdata = 32'hA5A5A5A5;
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({p0_gnt, p1_gnt, mem_req, p0_rvalid, p1_rvalid} !== 5'b0 ||
            mem_addr !== '0 || p0_rdata !== '0 || p1_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b%b mem_req=%b rvalid=%b%b mem_addr=%h rdata=%h/%h, required all 0",
                     p0_gnt, p1_gnt, mem_req, p0_rvalid, p1_rvalid, mem_addr, p0_rdata, p1_rdata);
        end
        next_cycle();
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_single_read();
        p0_req = 1; p0_we = 0; p0_addr = 24'h000010;
        @(negedge clk);
        n_tests++;
        if ({p0_gnt, p1_gnt, mem_req, mem_we} !== 4'b1010 || mem_addr !== 24'h000010) begin
            n_fail++;
            $display("FAIL single_read_issue: gnt=%b%b mem_req=%b we=%b addr=%h, required 1 0 1 0 000010",
                     p0_gnt, p1_gnt, mem_req, mem_we, mem_addr);
        end
        next_cycle();
        p0_req = 0;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++;
        if ({p0_rvalid, p0_err, p1_rvalid} !== 3'b100 || p0_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_read_resp: rvalid0=%b err0=%b rvalid1=%b rdata0=%h, required 1 0 0 deadbeef",
                     p0_rvalid, p0_err, p1_rvalid, p0_rdata);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_contention();
        logic [1:0] prev_gnt;
        do_reset();
        p0_req = 1; p1_req = 1; p0_addr = 24'h000040; p1_addr = 24'h000080;
        prev_gnt = 2'b00;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                p0_req = 0; p1_req = 0;
            end
            mem_rdata = 32'h1000 + 32'(i);
            @(negedge clk);
            n_tests++;
            if (i < 6 && {p0_gnt, p1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL contention_gnt[%0d]: gnt=%b%b, required %s", i, p0_gnt, p1_gnt,
                         (i % 2 == 0) ? "10" : "01");
            end
            n_tests++;
            if ({p0_rvalid, p1_rvalid} !== prev_gnt ||
                (prev_gnt != 0 && (p0_rdata | p1_rdata) !== mem_rdata)) begin
                n_fail++;
                $display("FAIL contention_rvalid[%0d]: rvalid=%b%b rdata=%h/%h, required %b data %h",
                         i, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, prev_gnt, mem_rdata);
            end
            prev_gnt = {p0_gnt, p1_gnt};
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_write();
        p1_req = 1; p1_we = 1; p1_be = 4'b0101; p1_addr = 24'h006FFC; p1_wdata = 32'h12345678;
        @(negedge clk);
        n_tests++;
        if ({p1_gnt, mem_req, mem_we} !== 3'b111 || mem_be !== 4'b0101 ||
            mem_addr !== 24'h006FFC || mem_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_issue: gnt1=%b req=%b we=%b be=%b addr=%h wdata=%h, required 1 1 1 0101 006ffc 12345678",
                     p1_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_tests++;
        if ({p1_rvalid, p1_err, p0_rvalid} !== 3'b100 || p1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL write_resp: rvalid1=%b err1=%b rvalid0=%b rdata1=%h, required 1 0 0 00000000",
                     p1_rvalid, p1_err, p0_rvalid, p1_rdata);
        end
        next_cycle();
    endtask

    task automatic test_out_of_range();
        p0_req = 1; p0_we = 0; p0_addr = 24'h007000;
        @(negedge clk);
        n_tests++;
        if ({p0_gnt, mem_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL oor_issue: gnt0=%b mem_req=%b, required 1 0", p0_gnt, mem_req);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        n_tests++;
        if ({p0_rvalid, p0_err} !== 2'b11 || p0_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_resp: rvalid0=%b err0=%b rdata0=%h, required 1 1 00000000",
                     p0_rvalid, p0_err, p0_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_midstream();
        p1_req = 1; p1_addr = 24'h000300;
        @(negedge clk);
        n_tests++;
        if (p1_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_grant: gnt1=%b, required 1", p1_gnt);
        end
        next_cycle();
        rst = 1; p0_req = 1; p0_addr = 24'h000304;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({p0_gnt, p1_gnt, mem_req} !== 3'b000 || p1_rvalid !== (i == 0)) begin
                n_fail++;
                $display("FAIL midrst_cycle[%0d]: gnt=%b%b mem_req=%b rvalid1=%b, required 00 0 %0d",
                         i, p0_gnt, p1_gnt, mem_req, p1_rvalid, (i == 0));
            end
            next_cycle();
        end
        rst = 0;
        @(negedge clk);
        n_tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_first: gnt=%b%b, required 10", p0_gnt, p1_gnt);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_lone_streak();
        p1_req = 1; p1_addr = 24'h000500;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({p0_gnt, p1_gnt} !== 2'b01) begin
                n_fail++;
                $display("FAIL streak_gnt[%0d]: gnt=%b%b, required 01", i, p0_gnt, p1_gnt);
            end
            next_cycle();
        end
        p0_req = 1;
        @(negedge clk);
        n_tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL streak_contend: gnt=%b%b, required 10", p0_gnt, p1_gnt);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return ADDR_W'(NWORDS * 4 - 4);
            1:       return ADDR_W'(NWORDS * 4);
            2:       return ADDR_W'($urandom);
            default: return ADDR_W'($urandom_range(0, NWORDS * 4 - 1));
        endcase
    endfunction

    task automatic test_random();
        int w;
        logic [ADDR_W-1:0] ea;
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!p0_req || p0_gnt) begin
                p0_req = $urandom_range(0, 1); p0_we = $urandom_range(0, 1);
                p0_be = 4'($urandom); p0_addr = rand_addr(); p0_wdata = $urandom;
            end
            if (!p1_req || p1_gnt) begin
                p1_req = $urandom_range(0, 1); p1_we = $urandom_range(0, 1);
                p1_be = 4'($urandom); p1_addr = rand_addr(); p1_wdata = $urandom;
            end
            mem_rdata = $urandom;
            @(negedge clk);
            w  = model_winner();
            ea = (w == 0) ? p0_addr : (w == 1) ? p1_addr : '0;
            n_tests++;
            if ({p0_gnt, p1_gnt} !== {w == 0, w == 1} || mem_req !== (w >= 0 && in_rng(ea)) ||
                mem_addr !== ea) begin
                n_fail++;
                $display("FAIL rand_issue[%0d]: gnt=%b%b mem_req=%b addr=%h, required %b%b %b %h",
                         c, p0_gnt, p1_gnt, mem_req, mem_addr, w == 0, w == 1, w >= 0 && in_rng(ea), ea);
            end
            n_tests++;
            if ({p0_rvalid, p1_rvalid} !== {exp_rvalid(0), exp_rvalid(1)} ||
                {p0_err, p1_err} !== {exp_rvalid(0) && m_pe, exp_rvalid(1) && m_pe} ||
                p0_rdata !== exp_rdata(0) || p1_rdata !== exp_rdata(1)) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: rvalid=%b%b err=%b%b rdata=%h/%h, required %b%b %b%b %h/%h",
                         c, p0_rvalid, p1_rvalid, p0_err, p1_err, p0_rdata, p1_rdata,
                         exp_rvalid(0), exp_rvalid(1), exp_rvalid(0) && m_pe, exp_rvalid(1) && m_pe,
                         exp_rdata(0), exp_rdata(1));
            end
            next_cycle();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_out_of_range();
        test_reset_midstream();
        test_lone_streak();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
